stack_ctrl: RTL

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl_if.sv | 27 ++
 rtl/stack_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl_if.sv
// Request/response bus of the stack controller.
//   master : requester side, drives req_valid/req_op/req_data and observes
//            req_ready plus the one-cycle response pulse.
//   slave  : controller side.
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. req_op/req_data must be stable while req_valid is
// high. There is no response back-pressure. resp_valid is a single-cycle
// pulse, and resp_data/resp_err are meaningful only while it is high.
interface stack_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/stack_ctrl.sv
// Stack controller. It sequences push, pop and set-SP requests against an
// external SP register and a single-port stack RAM. SP points to the next
// free word.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   bus          : stack_ctrl_if.slave, the request/response handshake
//   sp_value     : current SP from the SP register
//   sp_drive     : SP command (00 hold, 01 inc, 10 dec, 11 load)
//   sp_set       : load value used with sp_drive=11
//   mem_addr     : RAM word address
//   mem_we       : RAM write strobe
//   mem_wdata    : RAM write data
//   mem_re       : RAM read strobe (the read data arrives one cycle later)
//   mem_rdata    : RAM read data
//   dbg_state_o  : current FSM state, for observation
module stack_ctrl #(
  parameter logic [31:0] STACK_BASE  = 32'd0,
  parameter logic [31:0] STACK_DEPTH = 32'd256
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus,
  input  logic [31:0]  sp_value,
  output logic [1:0]   sp_drive,
  output logic [31:0]  sp_set,
  output logic [31:0]  mem_addr,
  output logic         mem_we,
  output logic [31:0]  mem_wdata,
  output logic         mem_re,
  input  logic [31:0]  mem_rdata,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH    = 3'd1,
    S_POP_DEC = 3'd2,
    S_POP_RD  = 3'd3,
    S_POP_CAP = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_SET  = 2'b11;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_INC  = 2'b01;
  localparam logic [1:0] SP_DEC  = 2'b10;
  localparam logic [1:0] SP_LOAD = 2'b11;

  localparam logic [31:0] TOP_ADDR = STACK_BASE + STACK_DEPTH;

  state_t      state_q;
  logic [1:0]  sp_drive_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_data_q;

  logic accept;
  logic is_full;
  logic is_empty;
  logic set_in_range;
  logic set_ok;

  assign accept       = bus.req_valid && (state_q == S_IDLE);
  assign is_full      = (sp_value == TOP_ADDR);
  assign is_empty     = (sp_value == STACK_BASE);
  assign set_in_range = (bus.req_data >= STACK_BASE) && (bus.req_data <= TOP_ADDR);
  // The SP load has to land on the acceptance edge itself so that a set
  // completes in one cycle. For that reason this one command is decoded
  // from the live request and is not taken from a register.
  assign set_ok       = accept && (bus.req_op == OP_SET) && set_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sp_drive_q   <= SP_HOLD;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'd0;
    end else begin
      // Strobes are high for exactly one state, so each one is cleared by default.
      sp_drive_q   <= SP_HOLD;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            case (bus.req_op)
              OP_PUSH: begin
                if (is_full) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_data_q  <= 32'd0;
                end else begin
                  // The write strobe and SP increment are set up here so that
                  // both are live for the single PUSH cycle.
                  state_q     <= S_PUSH;
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= bus.req_data;
                  sp_drive_q  <= SP_INC;
                end
              end
              OP_POP: begin
                if (is_empty) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_data_q  <= 32'd0;
                end else begin
                  state_q    <= S_POP_DEC;
                  sp_drive_q <= SP_DEC;
                end
              end
              OP_SET: begin
                state_q      <= S_RESP;
                resp_valid_q <= 1'b1;
                resp_err_q   <= !set_in_range;
                resp_data_q  <= 32'd0;
              end
              default: begin
                state_q      <= S_RESP;
                resp_valid_q <= 1'b1;
                resp_err_q   <= 1'b1;
                resp_data_q  <= 32'd0;
              end
            endcase
          end
        end
        S_PUSH: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= 32'd0;
        end
        S_POP_DEC: begin
          // SP has been decremented by the end of this cycle, so the read
          // in POP_RD addresses the top word.
          state_q  <= S_POP_RD;
          mem_re_q <= 1'b1;
        end
        S_POP_RD: begin
          state_q <= S_POP_CAP;
        end
        S_POP_CAP: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= mem_rdata;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          resp_err_q  <= 1'b0;
          resp_data_q <= 32'd0;
        end
        default: begin
          state_q     <= S_IDLE;
          resp_err_q  <= 1'b0;
          resp_data_q <= 32'd0;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;

  assign sp_drive  = set_ok ? SP_LOAD : sp_drive_q;
  assign sp_set    = set_ok ? bus.req_data : 32'd0;
  // The RAM address follows the live SP only while a strobe is active. In
  // POP_RD this is already the decremented value.
  assign mem_addr  = (mem_we_q || mem_re_q) ? sp_value : 32'd0;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;

  assign dbg_state_o = state_q;

endmodule
